// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - single-issue scheduler with hazard stalls and writeback-port scheduling (option macro: ISSUE_SCHED_BYPASS_EN)
module issue_scheduler #(
    parameter int SFU_LATENCY = 4,
    parameter int LD_LATENCY  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] rA,
    input  logic [4:0] rB,
    input  logic [4:0] rD,
    input  logic       alu,
    input  logic       sfu,
    input  logic       ld,
    input  logic       sd,
    input  logic       bez,
    input  logic       bnez,
    input  logic       nop,
    input  logic       br_done,
    output logic       issue_alu,
    output logic       issue_sfu,
    output logic       issue_ld,
    output logic       issue_sd,
    output logic       issue_br,
    output logic [4:0] issue_rd,
    output logic       wb_en,
    output logic [4:0] wb_rd,
    output logic [1:0] wb_src
);
    // slot k holds the writeback k cycles from now; the top slot stays empty so the
    // collision probe for the longest latency always reads a free slot
    localparam int DEPTH = SFU_LATENCY + 2;

    typedef enum logic {RUN, BR_WAIT} state_t;
    state_t state, state_next;

    logic [31:0] busy, busy_next, ready_regs;
    logic        res_v   [DEPTH];
    logic [4:0]  res_rd  [DEPTH];
    logic [1:0]  res_src [DEPTH];
    logic [3:0]  sfu_cnt, ld_cnt;
    logic        c_nop, c_alu, c_sfu, c_ld, c_sd, c_br;
    logic        writes, use_rb, rd_is_src, slot_taken, hazard, accept;
    logic [3:0]  wb_lat;
    logic [1:0]  src_code;

    // class decode: an explicit nop or no class bit at all is a nop; otherwise first set bit wins
    always_comb begin
        c_nop     = nop | ~(alu | sfu | ld | sd | bez | bnez);
        c_alu     = ~c_nop & alu;
        c_sfu     = ~c_nop & ~alu & sfu;
        c_ld      = ~c_nop & ~alu & ~sfu & ld;
        c_sd      = ~c_nop & ~alu & ~sfu & ~ld & sd;
        c_br      = ~c_nop & ~alu & ~sfu & ~ld & ~sd;
        writes    = c_alu | c_sfu | c_ld;
        use_rb    = c_alu | c_sfu;
        rd_is_src = c_sd | c_br;
        wb_lat    = c_sfu ? 4'(SFU_LATENCY) : (c_ld ? 4'(LD_LATENCY) : 4'd1);
        src_code  = c_sfu ? 2'b01 : (c_ld ? 2'b10 : 2'b00);
    end

    // hazard detection; unit counters hold the cycles left until the unit can take a new
    // op on the cycle after acceptance, so a value of 1 means free for the next issue
    always_comb begin
        ready_regs = ~busy;
`ifdef ISSUE_SCHED_BYPASS_EN
        if (res_v[0]) ready_regs[res_rd[0]] = 1'b1;
`endif
        slot_taken = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            if (res_v[k] && k == int'(wb_lat) + 1) slot_taken = 1'b1;
        hazard = (~c_nop & ~ready_regs[rA])
               | (use_rb & ~ready_regs[rB])
               | (rd_is_src & ~ready_regs[rD])
               | (writes & busy[rD])
               | (writes & slot_taken)
               | (c_sfu & (sfu_cnt > 4'd1))
               | ((c_ld | c_sd) & (ld_cnt > 4'd1));
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset) state <= RUN;
        else        state <= state_next;
    end

    // next state and acceptance
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            RUN: begin
                in_ready = reset & ~hazard;
                if (in_valid && in_ready && c_br) state_next = BR_WAIT;
            end
            BR_WAIT: if (br_done) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    assign accept = in_valid & in_ready;

    // scoreboard update: release at end of wb cycle, claim at acceptance; register 0 never busy
    always_comb begin
        busy_next = busy;
        if (res_v[0]) busy_next[res_rd[0]] = 1'b0;
        if (accept && writes && rD != 5'd0) busy_next[rD] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // issue strobes, unit occupancy and writeback reservation shift register
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy      <= '0;
            sfu_cnt   <= 4'd0;
            ld_cnt    <= 4'd0;
            issue_alu <= 1'b0;
            issue_sfu <= 1'b0;
            issue_ld  <= 1'b0;
            issue_sd  <= 1'b0;
            issue_br  <= 1'b0;
            issue_rd  <= 5'd0;
            for (int k = 0; k < DEPTH; k++) begin
                res_v[k]   <= 1'b0;
                res_rd[k]  <= 5'd0;
                res_src[k] <= 2'b00;
            end
        end else begin
            busy      <= busy_next;
            issue_alu <= accept & c_alu;
            issue_sfu <= accept & c_sfu;
            issue_ld  <= accept & c_ld;
            issue_sd  <= accept & c_sd;
            issue_br  <= accept & c_br;
            issue_rd  <= (accept && !c_nop) ? rD : 5'd0;
            if (accept && c_sfu)    sfu_cnt <= 4'(SFU_LATENCY);
            else if (sfu_cnt != 0)  sfu_cnt <= sfu_cnt - 4'd1;
            if (accept && c_ld)     ld_cnt  <= 4'(LD_LATENCY);
            else if (ld_cnt != 0)   ld_cnt  <= ld_cnt - 4'd1;
            for (int k = 0; k < DEPTH - 1; k++) begin
                res_v[k]   <= res_v[k+1];
                res_rd[k]  <= res_rd[k+1];
                res_src[k] <= res_src[k+1];
            end
            res_v[DEPTH-1]   <= 1'b0;
            res_rd[DEPTH-1]  <= 5'd0;
            res_src[DEPTH-1] <= 2'b00;
            if (accept && writes) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (k == int'(wb_lat)) begin
                        res_v[k]   <= 1'b1;
                        res_rd[k]  <= rD;
                        res_src[k] <= src_code;
                    end
                end
            end
        end
    end

    assign wb_en  = res_v[0];
    assign wb_rd  = res_rd[0];
    assign wb_src = res_src[0];

endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - scoreboard bench for issue_scheduler against a cycle-arithmetic reference model
module tb_issue_scheduler;
    localparam int S   = 4;
    localparam int LDL = 2;
`ifdef ISSUE_SCHED_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       reset, in_valid, in_ready;
    logic [4:0] rA, rB, rD;
    logic       alu, sfu, ld, sd, bez, bnez, nop, br_done;
    logic       issue_alu, issue_sfu, issue_ld, issue_sd, issue_br;
    logic [4:0] issue_rd, wb_rd;
    logic       wb_en;
    logic [1:0] wb_src;

    issue_scheduler #(.SFU_LATENCY(S), .LD_LATENCY(LDL)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rA(rA), .rB(rB), .rD(rD),
        .alu(alu), .sfu(sfu), .ld(ld), .sd(sd), .bez(bez), .bnez(bnez), .nop(nop),
        .br_done(br_done),
        .issue_alu(issue_alu), .issue_sfu(issue_sfu), .issue_ld(issue_ld),
        .issue_sd(issue_sd), .issue_br(issue_br), .issue_rd(issue_rd),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_src(wb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int kind; logic [4:0] rd; } iss_t;
    typedef struct { int cyc; logic [4:0] rd; logic [1:0] src; } wb_t;
    iss_t iq[$];
    wb_t  wq[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // reference model: everything is kept as absolute cycle numbers
    int busy_until[32];
    bit wb_res[int];
    int sfu_last, ld_last;
    bit in_br;

    function automatic int lat_of(input int cls);
        return (cls == 0) ? 1 : ((cls == 1) ? S : LDL);
    endfunction

    function automatic bit src_busy(input int c, input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return BYP ? (c < busy_until[r]) : (c <= busy_until[r]);
    endfunction

    // cls: 0 alu, 1 sfu, 2 ld, 3 sd, 4 bez, 5 bnez, 6 nop, 7 no class bit
    function automatic bit model_ready(input int c, input int cls, input logic [4:0] a, b, d);
        bit writes = (cls <= 2);
        if (in_br) return 1'b0;
        if (cls <= 5 && src_busy(c, a)) return 1'b0;
        if (cls <= 1 && src_busy(c, b)) return 1'b0;
        if (cls >= 3 && cls <= 5 && src_busy(c, d)) return 1'b0;
        if (writes && d != 5'd0 && c <= busy_until[d]) return 1'b0;
        if (writes && wb_res.exists(c + 1 + lat_of(cls))) return 1'b0;
        if (cls == 1 && c + 1 <= sfu_last) return 1'b0;
        if ((cls == 2 || cls == 3) && c + 1 <= ld_last) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_accept(input int t, input int cls, input logic [4:0] d);
        if (cls <= 5) iq.push_back('{t + 1, (cls >= 4) ? 4 : cls, d});
        if (cls <= 2) begin
            int w = t + 1 + lat_of(cls);
            wb_t e = '{w, d, (cls == 0) ? 2'b00 : ((cls == 1) ? 2'b01 : 2'b10)};
            int pos = wq.size();
            while (pos > 0 && wq[pos-1].cyc > w) pos--;
            wq.insert(pos, e);
            wb_res[w] = 1'b1;
            if (d != 5'd0) busy_until[d] = w;
        end
        if (cls == 1) sfu_last = t + S;
        if (cls == 2) ld_last = t + LDL;
        if (cls == 4 || cls == 5) in_br = 1'b1;
    endtask

    task automatic model_reset(input int c);
        foreach (busy_until[i]) busy_until[i] = -100;
        wb_res.delete();
        sfu_last = -100;
        ld_last  = -100;
        in_br    = 1'b0;
        while (iq.size() > 0 && iq[iq.size()-1].cyc > c) void'(iq.pop_back());
        while (wq.size() > 0 && wq[wq.size()-1].cyc > c) void'(wq.pop_back());
    endtask

    // one cycle of stimulus: drive on the falling edge, check in_ready, update the model
    task automatic drive(input bit rst_n, input bit v, input int cls, input logic [4:0] a, b, d,
                         input bit bd, output bit acc);
        bit er;
        int now;
        @(negedge clk);
        reset = rst_n; in_valid = v; rA = a; rB = b; rD = d; br_done = bd;
        {alu, sfu, ld, sd, bez, bnez, nop} = 7'b1000000 >> cls;
        #1;
        now = cyc;
        er  = rst_n && model_ready(now, cls, a, b, d);
        check("in_ready", int'(in_ready), int'(er));
        acc = v && er;
        if (!rst_n) model_reset(now);
        else begin
            if (in_br && bd) in_br = 1'b0;
            if (acc) model_accept(now, cls, d);
        end
    endtask

    task automatic present(input int cls, input logic [4:0] a, b, d, output int at);
        bit acc = 1'b0;
        at = -1;
        for (int i = 0; i < 40 && !acc; i++) begin
            drive(1'b1, 1'b1, cls, a, b, d, 1'b0, acc);
            if (acc) at = cyc;
        end
        check("accept_in_bound", int'(acc), 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 6, 5'd0, 5'd0, 5'd0, 1'b0, acc);
    endtask

    // monitor: pops the expectation due this cycle and compares the registered outputs
    always @(negedge clk) begin : monitor
        logic [4:0] exp_v;
        exp_v = 5'd0;
        if (iq.size() > 0 && iq[0].cyc == cyc) begin
            exp_v = 5'b10000 >> iq[0].kind;
            check("issue_rd", int'(issue_rd), int'(iq[0].rd));
            void'(iq.pop_front());
        end
        check("issue_strobes", int'({issue_alu, issue_sfu, issue_ld, issue_sd, issue_br}), int'(exp_v));
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
            check("wb_en", int'(wb_en), 1);
            check("wb_rd", int'(wb_rd), int'(wq[0].rd));
            check("wb_src", int'(wb_src), int'(wq[0].src));
            void'(wq.pop_front());
        end else begin
            check("wb_en_idle", int'(wb_en), 0);
        end
    end

    initial begin
        int t0, t1, t2, tr;
        bit acc;
        reset = 1'b0; in_valid = 1'b0; rA = 5'd0; rB = 5'd0; rD = 5'd0;
        {alu, sfu, ld, sd, bez, bnez, nop} = 7'b0; br_done = 1'b0;
        model_reset(0);

        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 0, 5'd1, 5'd0, 5'd1, 1'b0, acc);
        tr = cyc;
        present(0, 5'd0, 5'd0, 5'd1, t0);
        check("ready_after_reset", t0, tr + 1);
        present(0, 5'd0, 5'd0, 5'd2, t1);
        check("alu_back_to_back", t1 - t0, 1);
        idle(6);

        present(0, 5'd0, 5'd0, 5'd3, t0);
        present(0, 5'd3, 5'd0, 5'd4, t1);
        check("raw_delay", t1 - t0, BYP ? 2 : 3);
        idle(6);

        present(1, 5'd0, 5'd0, 5'd5, t0);
        idle(2);
        present(0, 5'd0, 5'd0, 5'd6, t1);
        check("wb_collision_delay", t1 - t0, 4);
        idle(8);

        present(1, 5'd0, 5'd0, 5'd7, t0);
        present(1, 5'd0, 5'd0, 5'd8, t1);
        check("sfu_struct_delay", t1 - t0, 4);
        idle(10);

        present(4, 5'd0, 5'd0, 5'd0, t0);
        for (int k = 1; k <= 4; k++) drive(1'b1, 1'b1, 0, 5'd0, 5'd0, 5'd9, k == 4, acc);
        present(0, 5'd0, 5'd0, 5'd9, t1);
        check("branch_resume", t1 - t0, 5);
        drive(1'b1, 1'b0, 6, 5'd0, 5'd0, 5'd0, 1'b1, acc);
        present(0, 5'd0, 5'd0, 5'd10, t2);
        check("br_done_in_run_ignored", t2 - t1, 2);
        present(5, 5'd0, 5'd0, 5'd0, t0);
        drive(1'b1, 1'b0, 6, 5'd0, 5'd0, 5'd0, 1'b1, acc);
        present(0, 5'd0, 5'd0, 5'd12, t1);
        check("bnez_fast_resume", t1 - t0, 2);
        idle(6);

        present(1, 5'd0, 5'd0, 5'd11, t0);
        present(2, 5'd0, 5'd0, 5'd12, t1);
        present(4, 5'd0, 5'd0, 5'd0, t2);
        drive(1'b0, 1'b1, 0, 5'd0, 5'd0, 5'd0, 1'b0, acc);
        drive(1'b0, 1'b1, 0, 5'd0, 5'd0, 5'd0, 1'b0, acc);
        tr = cyc;
        present(1, 5'd11, 5'd12, 5'd11, t0);
        check("reset_abandons_inflight", t0, tr + 1);
        idle(10);

        for (int i = 0; i < 500; i++) begin
            int cls = int'($urandom_range(0, 7));
            bit rst_n = ($urandom_range(0, 99) != 0);
            drive(rst_n, $urandom_range(0, 3) != 0, cls,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, acc);
        end

        idle(12);
        check("issue_queue_drained", iq.size(), 0);
        check("wb_queue_drained", wq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
